// File: rtl/btn_cond.sv
// Push-button conditioner: synchronizes four raw buttons, debounces a press,
// and reports a single accepted button code or a multi-button event per press.
module btn_cond #(
    parameter int DEB_CYC = 4,
    parameter int REL_CYC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] b,
    input  logic       en,
    output logic       press,
    output logic [1:0] ans,
    output logic       multi,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEB  = 2'd1,
        HELD = 2'd2,
        REL  = 2'd3
    } state_t;

    localparam logic [15:0] DEB_LAST = 16'(DEB_CYC - 1);
    localparam logic [15:0] REL_LAST = 16'(REL_CYC - 1);

    state_t      state, state_nx;
    logic [3:0]  sync1, sb;
    logic [3:0]  snap, snap_nx;
    logic [15:0] cnt, cnt_nx;
    logic        press_nx, multi_nx;
    logic [1:0]  ans_nx;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    function automatic logic [1:0] encode(input logic [3:0] v);
        logic [1:0] code;
        code = 2'd0;
        case (v)
            4'b0010: code = 2'd1;
            4'b0100: code = 2'd2;
            4'b1000: code = 2'd3;
            default: code = 2'd0;
        endcase
        return code;
    endfunction

    // NOTE: every register, synchronizer included, clears asynchronously so a
    // press in flight when reset hits can never surface as a pulse afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 4'b0000;
            sb    <= 4'b0000;
        end else begin
            sync1 <= b;
            sb    <= sync1;
        end
    end

    // NOTE: state registers use <= so every flop samples the pre-edge values
    // computed by the combinational block; = here would create ordering races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            snap  <= 4'b0000;
            cnt   <= 16'd0;
            press <= 1'b0;
            multi <= 1'b0;
            ans   <= 2'b00;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            snap  <= snap_nx;
            cnt   <= cnt_nx;
            press <= press_nx;
            multi <= multi_nx;
            ans   <= ans_nx;
            busy  <= (state_nx != IDLE);
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        snap_nx  = snap;
        cnt_nx   = cnt;
        press_nx = 1'b0;
        multi_nx = 1'b0;
        ans_nx   = ans;

        case (state)
            IDLE: begin
                if (sb != 4'b0000 && en) begin
                    state_nx = DEB;
                    snap_nx  = sb;
                    cnt_nx   = 16'd0;
                end
            end
            DEB: begin
                if (!en || sb != snap) begin
                    state_nx = IDLE;
                    cnt_nx   = 16'd0;
                end else if (cnt == DEB_LAST) begin
                    state_nx = HELD;
                    cnt_nx   = 16'd0;
                    if (is_onehot(snap)) begin
                        press_nx = 1'b1;
                        ans_nx   = encode(snap);
                    end else begin
                        multi_nx = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            HELD: begin
                // en is deliberately ignored: a held button must finish releasing.
                if (sb == 4'b0000) begin
                    state_nx = REL;
                    cnt_nx   = 16'd0;
                end
            end
            REL: begin
                if (sb != 4'b0000) begin
                    state_nx = HELD;
                    cnt_nx   = 16'd0;
                end else if (cnt == REL_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = 16'd0;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 16'd0;
            end
        endcase
    end

endmodule
